uart_word_loader: RTL and testbench
===================================

# uart_word_loader

Downstream consumer of the UART receiver: takes the receiver's one-cycle `done` strobe and data byte and runs a small load protocol on the byte stream. It packs consecutive bytes into little-endian words and issues one-cycle write strobes with an auto-incrementing address toward instruction/data memory. A baud-tick-driven timeout aborts a stalled transfer.

## Interface
- `BITS_DATA`, 8, width of one received byte.
- `WORD_BYTES`, 4, bytes per memory word (≥2).
- `ADDR_WIDTH`, 8, width of the word address.
- `CMD_LOAD`, 8'h4C, command byte that starts a load (ASCII 'L').
- `TIMEOUT_TICKS`, 1024, `i_tick` pulses allowed between bytes before abort (≥1).
- `i_clk`  in  1  system clock, all logic on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_rx_done`  in  1  one-cycle strobe: `i_rx_data` holds a valid byte.
- `i_rx_data`  in  BITS_DATA  received byte, sampled only when `i_rx_done`=1.
- `i_tick`  in  1  baud oversampling tick (same tick driving the receiver).
- `o_wr_en`  out  1  one-cycle write strobe.
- `o_wr_addr`  out  ADDR_WIDTH  word address, valid while `o_wr_en`=1.
- `o_wr_data`  out  WORD_BYTES*BITS_DATA  assembled word, valid while `o_wr_en`=1.
- `o_load_done`  out  1  one-cycle pulse, coincident with the last `o_wr_en`.
- `o_error`  out  1  level; set on abort, cleared when the next `CMD_LOAD` is accepted.
- `o_busy`  out  1  high in COUNT and DATA states.

## Operation
- Protocol: `CMD_LOAD`, then one count byte N (number of words, 1..2^BITS_DATA−1), then N×WORD_BYTES data bytes. Within each word the first byte received is the LSB.
- States: IDLE, COUNT, DATA.
- IDLE:
  - A byte equal to `CMD_LOAD` → COUNT. This clears `o_error`, the address counter, the byte counter and the timeout counter.
  - Any other byte is ignored, with no output change.
- COUNT, on a received byte:
  - N=0 → set `o_error`, go to IDLE.
  - Otherwise latch N into the remaining-word counter → DATA.
- DATA, on each received byte:
  - Shift into the word register as {byte, word[MSBs:BITS_DATA]}.
  - Increment the byte counter.
  - On byte WORD_BYTES of a word: on the next cycle assert `o_wr_en` with the full word and the current address. Then increment the address, reset the byte counter and decrement the remaining-word counter.
  - When the remaining count reaches 0: `o_load_done` is asserted together with that final `o_wr_en`, and the state goes to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. N greater than 2^ADDR_WIDTH wraps the address to 0 and overwrites; no error is flagged.
- Timeout, active in COUNT and DATA only:
  - Counter clears on every received byte and increments on every `i_tick`.
  - Reaching TIMEOUT_TICKS → set `o_error`, go to IDLE. The partially assembled word is discarded and no write is issued.
- `CMD_LOAD` appearing inside COUNT or DATA is treated as an ordinary data/count byte, never as a restart.

## Timing
- Reset (async assert, sync release): state IDLE, all counters 0, word register 0. `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_load_done`=0, `o_error`=0, `o_busy`=0.
- All outputs are registered.
- Latency: last byte's `i_rx_done` in cycle k → `o_wr_en`/`o_load_done` in cycle k+1, each high for exactly one cycle.
- `o_wr_addr`/`o_wr_data` hold their values after the strobe until the next write.
- `o_busy` rises the cycle after `CMD_LOAD` is accepted and falls the cycle after the last byte or the abort.
- A byte accepted in cycle k+1 (during a write strobe) is processed normally as part of the next word. No bubble is required.
- Same-cycle `i_rx_done` and the terminal `i_tick`: the byte wins. It is processed and the timeout counter clears.
- Reset mid-load: immediate return to the reset values. No write is issued for the partial word.

## Test plan
- Load N=2 with bytes 4C 02 11 22 33 44 55 66 77 88 → writes addr 0 = 0x44332211 and addr 1 = 0x88776655. `o_load_done` is asserted with the second write, `o_error`=0, `o_busy` is low afterwards.
- Send bytes 00 FF 4C before the loader sees its command → 00 and FF are ignored with no writes. 4C then enters COUNT and `o_busy`=1.
- Send 4C 00 → `o_error`=1, no write, IDLE. A following 4C clears `o_error`.
- Send 4C 01 AA BB, then 1024 `i_tick` pulses with no byte → `o_error`=1, `o_wr_en` never asserted, `o_busy`=0.
- Reach tick 1023 after a byte, then give a byte and the 1024th tick in the same cycle → no abort. The load completes normally.
- With ADDR_WIDTH=2, load N=5 → write addresses 0,1,2,3,0. Also assert `i_reset` after 2 data bytes → outputs return to 0 immediately and no write occurs.

Source files
------------

// File: rtl/uart_word_loader_if.sv
// uart_word_loader_if: byte stream in from the UART receiver, word writes out toward memory.
interface uart_word_loader_if #(
   parameter int BITS_DATA  = 8,
   parameter int WORD_BYTES = 4,
   parameter int ADDR_WIDTH = 8
);
   logic                             i_rx_done;
   logic [BITS_DATA-1:0]             i_rx_data;
   logic                             i_tick;
   logic                             o_wr_en;
   logic [ADDR_WIDTH-1:0]            o_wr_addr;
   logic [WORD_BYTES*BITS_DATA-1:0]  o_wr_data;
   logic                             o_load_done;
   logic                             o_error;
   logic                             o_busy;
   modport slave (
      input  i_rx_done, i_rx_data, i_tick,
      output o_wr_en, o_wr_addr, o_wr_data, o_load_done, o_error, o_busy
   );
   modport master (
      output i_rx_done, i_rx_data, i_tick,
      input  o_wr_en, o_wr_addr, o_wr_data, o_load_done, o_error, o_busy
   );
endinterface

// File: rtl/uart_word_loader.sv
// uart_word_loader: runs the 'L' + count + data load protocol, packing bytes into little-endian words
// and issuing one-cycle writes with an auto-incrementing address; a tick-based timeout aborts stalls.
module uart_word_loader #(
   parameter int                   BITS_DATA     = 8,
   parameter int                   WORD_BYTES    = 4,
   parameter int                   ADDR_WIDTH    = 8,
   parameter logic [BITS_DATA-1:0] CMD_LOAD      = 8'h4C,
   parameter int                   TIMEOUT_TICKS = 1024
) (
   input logic                i_clk,
   input logic                i_reset,
   uart_word_loader_if.slave  bus
);
   localparam int WW = WORD_BYTES * BITS_DATA;
   localparam int BW = $clog2(WORD_BYTES);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_TICKS - 1);

   typedef enum logic [1:0] {IDLE, COUNT, DATA} state_t;

   state_t                state, state_n;
   logic [WW-1:0]         word, word_n, shifted;
   logic [BW-1:0]         byte_cnt, byte_n;
   logic [BITS_DATA-1:0]  remain, remain_n;
   logic [ADDR_WIDTH-1:0] addr, addr_n;
   logic [TW-1:0]         to_cnt, to_n;
   logic                  wr_en, wr_en_n;
   logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n;
   logic [WW-1:0]         wr_data, wr_data_n;
   logic                  done, done_n;
   logic                  error, error_n;
   logic                  busy;

   // First byte of a word ends up in the LSBs after WORD_BYTES shifts.
   assign shifted = {bus.i_rx_data, word[WW-1:BITS_DATA]};

   always_comb begin
      state_n   = state;
      word_n    = word;
      byte_n    = byte_cnt;
      remain_n  = remain;
      addr_n    = addr;
      to_n      = to_cnt;
      wr_en_n   = 1'b0;
      done_n    = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;
      error_n   = error;
      case (state)
         IDLE: if (bus.i_rx_done && bus.i_rx_data == CMD_LOAD) begin
            state_n = COUNT;
            error_n = 1'b0;
            addr_n  = '0;
            byte_n  = '0;
            to_n    = '0;
            word_n  = '0;
         end
         COUNT: if (bus.i_rx_done) begin
            to_n     = '0;
            state_n  = (bus.i_rx_data == '0) ? IDLE : DATA;
            error_n  = (bus.i_rx_data == '0) ? 1'b1 : error;
            remain_n = bus.i_rx_data;
         end
         DATA: if (bus.i_rx_done) begin
            to_n   = '0;
            word_n = shifted;
            byte_n = byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) begin
               byte_n    = '0;
               wr_en_n   = 1'b1;
               wr_addr_n = addr;
               wr_data_n = shifted;
               addr_n    = addr + 1'b1;
               remain_n  = remain - 1'b1;
               done_n    = (remain == BITS_DATA'(1));
               state_n   = (remain == BITS_DATA'(1)) ? IDLE : DATA;
            end
         end
         default: state_n = IDLE;
      endcase
      // A byte arriving with the terminal tick wins, so only tick when no byte came in.
      if (state != IDLE && !bus.i_rx_done && bus.i_tick) begin
         to_n    = (to_cnt == LAST_TICK) ? '0 : to_cnt + 1'b1;
         error_n = (to_cnt == LAST_TICK) ? 1'b1 : error;
         state_n = (to_cnt == LAST_TICK) ? IDLE : state;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= IDLE;
         word     <= '0;
         byte_cnt <= '0;
         remain   <= '0;
         addr     <= '0;
         to_cnt   <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         done     <= 1'b0;
         error    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         word     <= word_n;
         byte_cnt <= byte_n;
         remain   <= remain_n;
         addr     <= addr_n;
         to_cnt   <= to_n;
         wr_en    <= wr_en_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
         done     <= done_n;
         error    <= error_n;
         busy     <= (state_n != IDLE);
      end
   end

   assign bus.o_wr_en     = wr_en;
   assign bus.o_wr_addr   = wr_addr;
   assign bus.o_wr_data   = wr_data;
   assign bus.o_load_done = done;
   assign bus.o_error     = error;
   assign bus.o_busy      = busy;
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: directed load-protocol scenarios on a default loader and a 2-bit-address twin.
module tb_uart_word_loader;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   wr_cnt = 0;
   int   snap;
   logic [1:0] q2[$];

   uart_word_loader_if bus();
   uart_word_loader_if #(.ADDR_WIDTH(2)) bus2();

   uart_word_loader dut (.i_clk(clk), .i_reset(rst), .bus(bus.slave));
   uart_word_loader #(.ADDR_WIDTH(2)) dut2 (.i_clk(clk), .i_reset(rst), .bus(bus2.slave));

   assign bus2.i_rx_done = bus.i_rx_done;
   assign bus2.i_rx_data = bus.i_rx_data;
   assign bus2.i_tick    = bus.i_tick;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.o_wr_en) wr_cnt++;
      if (bus2.o_wr_en) q2.push_back(bus2.o_wr_addr);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic with_tick = 1'b0);
      @(posedge clk); #1;
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = b;
      bus.i_tick    = with_tick;
      @(posedge clk); #1;
      bus.i_rx_done = 1'b0;
      bus.i_tick    = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.i_tick = 1'b1;
      end
      @(posedge clk); #1;
      bus.i_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.i_rx_done = 1'b0;
      bus.i_rx_data = '0;
      bus.i_tick    = 1'b0;
      idle(3);
      check("rst_wr_en", bus.o_wr_en, 0);
      check("rst_wr_addr", bus.o_wr_addr, 0);
      check("rst_wr_data", bus.o_wr_data, 0);
      check("rst_done", bus.o_load_done, 0);
      check("rst_error", bus.o_error, 0);
      check("rst_busy", bus.o_busy, 0);
      @(negedge clk) rst = 1'b0;
      idle(2);

      // Noise before the command is ignored
      send(8'h00);
      send(8'hFF);
      idle(1);
      check("noise_busy", bus.o_busy, 0);
      check("noise_writes", wr_cnt, 0);
      send(8'h4C);
      check("cmd_busy", bus.o_busy, 1);

      // Two-word load
      send(8'h02);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      check("w0_en", bus.o_wr_en, 1);
      check("w0_addr", bus.o_wr_addr, 0);
      check("w0_data", bus.o_wr_data, 64'h44332211);
      check("w0_done", bus.o_load_done, 0);
      send(8'h55);
      check("w0_pulse_len", bus.o_wr_en, 0);
      check("w0_hold", bus.o_wr_data, 64'h44332211);
      send(8'h66); send(8'h77); send(8'h88);
      check("w1_en", bus.o_wr_en, 1);
      check("w1_addr", bus.o_wr_addr, 1);
      check("w1_data", bus.o_wr_data, 64'h88776655);
      check("w1_done", bus.o_load_done, 1);
      check("w1_error", bus.o_error, 0);
      check("w1_busy", bus.o_busy, 0);
      idle(1);
      check("post_en", bus.o_wr_en, 0);
      check("post_done", bus.o_load_done, 0);
      check("post_addr_hold", bus.o_wr_addr, 1);
      check("load_writes", wr_cnt, 2);

      // Zero count is an error, cleared by the next command
      send(8'h4C);
      send(8'h00);
      check("n0_error", bus.o_error, 1);
      check("n0_busy", bus.o_busy, 0);
      idle(1);
      check("n0_writes", wr_cnt, 2);
      send(8'h4C);
      check("n0_clear", bus.o_error, 0);
      check("n0_rebusy", bus.o_busy, 1);

      // Timeout mid-word: 1023 ticks survive, the 1024th aborts
      send(8'h01);
      send(8'hAA);
      send(8'hBB);
      ticks(1023);
      check("to_1023_busy", bus.o_busy, 1);
      check("to_1023_error", bus.o_error, 0);
      ticks(1);
      check("to_error", bus.o_error, 1);
      check("to_busy", bus.o_busy, 0);
      idle(2);
      check("to_writes", wr_cnt, 2);

      // Byte coincident with the terminal tick wins
      send(8'h4C);
      send(8'h01);
      send(8'h11);
      ticks(1023);
      send(8'h22, 1'b1);
      check("race_error", bus.o_error, 0);
      check("race_busy", bus.o_busy, 1);
      ticks(1023);
      send(8'h33);
      check("race_clear", bus.o_error, 0);
      send(8'h44);
      check("race_en", bus.o_wr_en, 1);
      check("race_addr", bus.o_wr_addr, 0);
      check("race_data", bus.o_wr_data, 64'h44332211);
      check("race_done", bus.o_load_done, 1);

      // Five words: default loader counts 0..4, 2-bit twin wraps to 0
      idle(1);
      q2.delete();
      snap = wr_cnt;
      send(8'h4C);
      send(8'h05);
      for (int w = 0; w < 5; w++)
         for (int b = 0; b < 4; b++) send(8'(16 * w + b));
      check("n5_addr", bus.o_wr_addr, 4);
      check("n5_data", bus.o_wr_data, 64'h43424140);
      check("n5_done", bus.o_load_done, 1);
      check("n5_aw2_addr", bus2.o_wr_addr, 0);
      check("n5_aw2_done", bus2.o_load_done, 1);
      check("n5_aw2_error", bus2.o_error, 0);
      idle(1);
      check("n5_writes", wr_cnt - snap, 5);
      check("n5_aw2_count", q2.size(), 5);
      if (q2.size() == 5) begin
         check("n5_aw2_a0", q2[0], 0);
         check("n5_aw2_a1", q2[1], 1);
         check("n5_aw2_a2", q2[2], 2);
         check("n5_aw2_a3", q2[3], 3);
         check("n5_aw2_a4", q2[4], 0);
      end

      // Reset mid-load
      snap = wr_cnt;
      send(8'h4C);
      send(8'h01);
      send(8'hAA);
      send(8'hBB);
      check("mid_busy", bus.o_busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_addr", bus.o_wr_addr, 0);
      check("mid_rst_data", bus.o_wr_data, 0);
      check("mid_rst_busy", bus.o_busy, 0);
      check("mid_rst_en", bus.o_wr_en, 0);
      @(negedge clk) rst = 1'b0;
      send(8'hCC);
      send(8'hDD);
      idle(1);
      check("mid_idle_busy", bus.o_busy, 0);
      check("mid_writes", wr_cnt - snap, 0);
      send(8'h4C);
      send(8'h01);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      check("after_rst_addr", bus.o_wr_addr, 0);
      check("after_rst_data", bus.o_wr_data, 64'h04030201);
      check("after_rst_done", bus.o_load_done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
